// File: rtl/rns_fir_pkg.sv
// Shared types and constants for the RNS FIR engine: moduli, operation and
// state encodings, and the per-channel coefficient residue table.
package rns_fir_pkg;

   localparam int unsigned M0 = 233;
   localparam int unsigned M1 = 239;
   localparam int unsigned M2 = 241;
   localparam int unsigned M3 = 251;

   typedef logic [7:0] residue_t;

   typedef enum logic [1:0] {
      OP_IDLE    = 2'b00,
      OP_LOAD    = 2'b01,
      OP_COMPUTE = 2'b10,
      OP_READ    = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_COMPUTE,
      ST_DONE
   } state_t;

   // Modulus of residue channel ch (channel j occupies bits [8j+7:8j]).
   function automatic int unsigned modulus(input int unsigned ch);
      case (ch)
         0:       return M0;
         1:       return M1;
         2:       return M2;
         default: return M3;
      endcase
   endfunction

   // Residue of integer tap h[tap] = tap+1 in channel ch; valid for any tap count.
   function automatic residue_t coef_residue(input int unsigned ch, input int unsigned tap);
      return residue_t'((tap + 1) % modulus(ch));
   endfunction

endpackage

// File: rtl/rns_fir_engine_if.sv
// Sequencer-facing bus of the RNS FIR engine: operation, address, sample in,
// result out and completion flag.
interface rns_fir_engine_if;
   logic [31:0] addr;
   logic [31:0] x_rns;
   logic [1:0]  operation;
   logic [31:0] y_rns;
   logic        done;

   modport master (output addr, x_rns, operation, input y_rns, done);
   modport slave  (input addr, x_rns, operation, output y_rns, done);
endinterface

// File: rtl/rns_mac_channel.sv
// One modulus channel: reduced multiply-accumulate with clear. The reduced
// running sum including the current tap is exposed so the caller can capture
// the final value of a row on the same edge the accumulator is cleared.
module rns_mac_channel
   import rns_fir_pkg::*;
#(
   parameter int unsigned M = 233
) (
   input  logic     clk,
   input  logic     reset,
   input  logic     clear,
   input  logic     mac_en,
   input  logic     last,
   input  residue_t coef,
   input  residue_t x,
   output residue_t sum
);

   residue_t    acc;
   logic [15:0] prod;
   residue_t    prod_red;
   logic [8:0]  acc_sum;

   // Full 16-bit product, reduced, then added to acc and reduced again; both
   // operands are < M so the 9-bit sum never exceeds 2M-2.
   always_comb begin
      prod     = 16'(coef) * 16'(x);
      prod_red = residue_t'(prod % 16'(M));
      acc_sum  = {1'b0, acc} + {1'b0, prod_red};
      sum      = residue_t'(acc_sum % 9'(M));
   end

   // Accumulator: cleared on start and after the last tap of each output.
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block ordering.
      if (!reset) begin
         acc <= '0;
      end else if (clear) begin
         acc <= '0;
      end else if (mac_en) begin
         acc <= last ? '0 : sum;
      end
   end

endmodule

// File: rtl/rns_fir_engine.sv
// RNS FIR responder: loads residue samples, runs y[k] = sum h[i]*x[k-i] one
// MAC per cycle in four modulus channels, then serves results by address.
module rns_fir_engine
   import rns_fir_pkg::*;
#(
   parameter int unsigned N            = 10,
   parameter int unsigned SIGNAL_COUNT = 10
) (
   input  logic            clk,
   input  logic            reset,
   rns_fir_engine_if.slave bus
);

   localparam int unsigned KW = (SIGNAL_COUNT > 1) ? $clog2(SIGNAL_COUNT) : 1;
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

   state_t        state;
   state_t        next_state;
   op_t           op;
   logic [31:0]   sample [SIGNAL_COUNT];
   logic [31:0]   result [SIGNAL_COUNT];
   logic [KW-1:0] k;
   logic [IW-1:0] i;
   logic [KW-1:0] addr_idx;
   logic [KW-1:0] k_minus_i;
   logic          addr_ok;
   logic          tap_last;
   logic          row_last;
   logic          sample_we;
   logic          start;
   logic          mac_en;
   logic          read_en;
   logic          done_d;
   logic [31:0]   x_sel;
   residue_t      ch_sum [4];
   logic [31:0]   sum_word;
   logic [31:0]   y_q;
   logic          done_q;

   assign op        = op_t'(bus.operation);
   assign addr_ok   = bus.addr < SIGNAL_COUNT;
   assign addr_idx  = bus.addr[KW-1:0];
   assign tap_last  = i == IW'(N - 1);
   assign row_last  = k == KW'(SIGNAL_COUNT - 1);
   assign k_minus_i = k - KW'(i);
   assign sum_word  = {ch_sum[3], ch_sum[2], ch_sum[1], ch_sum[0]};
   assign bus.y_rns = y_q;
   assign bus.done  = done_q;

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= next_state;
   end

   // Next-state logic; operation is ignored while computing.
   always_comb begin
      // NOTE: default first so every path assigns next_state and no latch forms.
      next_state = state;
      case (state)
         ST_IDLE:    if (op == OP_LOAD)       next_state = ST_LOAD;
         ST_LOAD:    if (op == OP_COMPUTE)    next_state = ST_COMPUTE;
         ST_COMPUTE: if (tap_last && row_last) next_state = ST_DONE;
         ST_DONE:    if (op == OP_LOAD)       next_state = ST_LOAD;
         default:                             next_state = ST_IDLE;
      endcase
   end

   // Control decode; done is registered so it rises one edge after the last MAC.
   always_comb begin
      sample_we = (state != ST_COMPUTE) && (op == OP_LOAD) && addr_ok;
      start     = (state == ST_LOAD) && (op == OP_COMPUTE);
      mac_en    = (state == ST_COMPUTE);
      read_en   = (state == ST_DONE) && (op == OP_READ);
      done_d    = (state == ST_DONE) && (op != OP_LOAD);
   end

   // Output index k and tap index i; i wraps after each full row.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         k <= '0;
         i <= '0;
      end else if (start) begin
         k <= '0;
         i <= '0;
      end else if (mac_en) begin
         if (tap_last) begin
            i <= '0;
            k <= k + 1'b1;
         end else begin
            i <= i + 1'b1;
         end
      end
   end

   // Sample feeding the current tap; taps reaching before x[0] contribute zero.
   always_comb begin
      x_sel = '0;
      if (32'(i) <= 32'(k)) x_sel = sample[k_minus_i];
   end

   for (genvar j = 0; j < 4; j++) begin : g_ch
      residue_t coef_tab [N];
      for (genvar t = 0; t < N; t++) begin : g_tap
         assign coef_tab[t] = coef_residue(j, t);
      end

      rns_mac_channel #(.M(modulus(j))) u_mac (
         .clk    (clk),
         .reset  (reset),
         .clear  (start),
         .mac_en (mac_en),
         .last   (tap_last),
         .coef   (coef_tab[i]),
         .x      (x_sel[8*j +: 8]),
         .sum    (ch_sum[j])
      );
   end

   // Sample/result storage, read register and done flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: the buffers must read back as zero after reset, so they are
         // built from resettable flops rather than an inferred RAM.
         for (int n = 0; n < SIGNAL_COUNT; n++) begin
            sample[n] <= '0;
            result[n] <= '0;
         end
         y_q    <= '0;
         done_q <= 1'b0;
      end else begin
         if (sample_we)         sample[addr_idx] <= bus.x_rns;
         if (mac_en && tap_last) result[k]        <= sum_word;
         if (read_en)           y_q              <= addr_ok ? result[addr_idx] : '0;
         done_q <= done_d;
      end
   end

endmodule

// File: tb/tb_rns_fir_engine.sv
// Directed bench for rns_fir_engine: load / compute / read scenarios with
// hand-computed residues, latency count, mid-compute reset and reload.
module tb_rns_fir_engine;
   import rns_fir_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   rns_fir_engine_if bus();

   rns_fir_engine dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // pattern 0: x[n]=n, 1: x[n]=9-n, 2: x[n]=200; extra adds an out-of-range write.
   task automatic load_samples(input int pattern, input bit extra);
      logic [7:0] v;
      for (int n = 0; n < 10; n++) begin
         if (pattern == 0)      v = 8'(n);
         else if (pattern == 1) v = 8'(9 - n);
         else                   v = 8'd200;
         @(negedge clk);
         bus.operation = OP_LOAD;
         bus.addr      = 32'(n);
         bus.x_rns     = {4{v}};
         if (n == 0) begin
            @(posedge clk);
            #1 check("done_low_after_load", {31'b0, bus.done}, 32'd0);
         end
      end
      if (extra) begin
         @(negedge clk);
         bus.addr  = 32'd10;
         bus.x_rns = 32'hFFFF_FFFF;
      end
   endtask

   // Issues op 10 and counts edges until done; optionally toggles op to 01
   // early in the run, or asserts reset at a given compute cycle.
   task automatic compute(input bit toggle, input int reset_at);
      int c;
      bit seen;
      @(negedge clk);
      bus.operation = OP_COMPUTE;
      bus.addr      = 32'd0;
      @(posedge clk);
      #1 bus.operation = OP_IDLE;
      c    = 0;
      seen = 1'b0;
      while (!seen && c < 300) begin
         @(posedge clk);
         #1 c++;
         if (toggle) begin
            if (c >= 3 && c <= 6) bus.operation = OP_LOAD;
            else                  bus.operation = OP_IDLE;
         end
         if (reset_at != 0 && c == reset_at) begin
            #2 reset = 1'b0;
            #1;
            check("reset_done_async", {31'b0, bus.done}, 32'd0);
            check("reset_y_async", bus.y_rns, 32'd0);
            @(negedge clk);
            reset = 1'b1;
            return;
         end
         if (bus.done) seen = 1'b1;
      end
      check("done_latency", 32'(c), 32'd101);
   endtask

   task automatic read(input logic [31:0] a, input logic [31:0] exp, input string tag);
      @(negedge clk);
      bus.operation = OP_READ;
      bus.addr      = a;
      @(posedge clk);
      #1 check(tag, bus.y_rns, exp);
   endtask

   initial begin
      bus.operation = OP_IDLE;
      bus.addr      = '0;
      bus.x_rns     = '0;
      #12;
      check("reset_done", {31'b0, bus.done}, 32'd0);
      check("reset_y", bus.y_rns, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // Ramp 0..9 plus stray write at addr 10; op toggled to 01 mid-compute.
      load_samples(0, 1'b1);
      compute(1'b1, 0);
      read(32'd0, 32'h0000_0000, "ramp_y0");
      read(32'd1, 32'h0101_0101, "ramp_y1");
      read(32'd2, 32'h0404_0404, "ramp_y2");
      read(32'd9, 32'hA5A5_A5A5, "ramp_y9");
      read(32'd10, 32'h0000_0000, "read_addr10");
      read(32'hFFFF_FFFF, 32'h0000_0000, "read_addr_max");
      read(32'd9, 32'hA5A5_A5A5, "ramp_y9_again");
      @(negedge clk);
      bus.operation = OP_IDLE;
      bus.addr      = 32'd1;
      @(posedge clk);
      #1 check("y_hold", bus.y_rns, 32'hA5A5_A5A5);
      check("done_high", {31'b0, bus.done}, 32'd1);

      // Reload from DONE with 9..0: y0 = 9, y9 = 330.
      load_samples(1, 1'b0);
      compute(1'b0, 0);
      read(32'd0, 32'h0909_0909, "rev_y0");
      read(32'd9, 32'h4F59_5B61, "rev_y9");

      // Reset in the middle of a compute.
      load_samples(2, 1'b0);
      compute(1'b0, 50);

      // With the sample buffer cleared by reset, every result must be zero.
      @(negedge clk);
      bus.operation = OP_LOAD;
      bus.addr      = 32'd10;
      bus.x_rns     = 32'hFFFF_FFFF;
      compute(1'b0, 0);
      read(32'd9, 32'h0000_0000, "cleared_y9");
      read(32'd0, 32'h0000_0000, "cleared_y0");

      // Constant 200 loaded from IDLE: per-channel modular wrap.
      @(negedge clk);
      bus.operation = OP_IDLE;
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      load_samples(2, 1'b1);
      compute(1'b0, 0);
      read(32'd0, 32'hC8C8_C8C8, "const_y0");
      read(32'd1, 32'h6276_7A86, "const_y1");
      read(32'd9, 32'hCF9B_0631, "const_y9");

      @(negedge clk);
      bus.operation = OP_IDLE;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rns_fir_engine.md
# rns_fir_engine

RNS-domain FIR responder serving the four-phase operation protocol issued by the top-level sequencer: load samples, compute, read back results. It stores `SIGNAL_COUNT` residue-encoded samples and computes `y[k] = sum h[i]*x[k-i]` independently in four modulus channels. Results are then served by address. It sits between `convertor_int_to_rns` (sample input) and `convertor_rns_to_int` (result output).

## Interface
- `N`, 10, tap count.
- `SIGNAL_COUNT`, 10, number of samples and results.
- `M0`/`M1`/`M2`/`M3`, 233/239/241/251, moduli. Residue `j` occupies bits `[8j+7:8j]`.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low.
- `addr` input 32: sample write index (LOAD) or result read index (READ).
- `x_rns` input 32: four 8-bit residues of the sample.
- `operation` input 2: 00 idle, 01 load, 10 compute, 11 read.
- `y_rns` output 32: four 8-bit residues of `result[addr]`.
- `done` output 1: results valid.

## Operation
- States: IDLE, LOAD, COMPUTE, DONE.
- IDLE:
  - op 01 -> LOAD, and the sample is written in the same cycle.
  - Other ops are ignored.
- LOAD:
  - Each cycle with op 01 and `addr < SIGNAL_COUNT`: `sample[addr] <= x_rns`.
  - `addr >= SIGNAL_COUNT` is ignored. The sequencer presents `addr == SIGNAL_COUNT` once; this must not corrupt the buffer.
  - op 10 -> COMPUTE, clearing counters and accumulators.
- COMPUTE:
  - Outer counter `k` runs 0..`SIGNAL_COUNT`-1. Inner counter `i` runs 0..`N`-1.
  - One MAC per cycle in all four channels: `acc_j <= (acc_j + (h_j[i]*x_j[k-i]) mod Mj) mod Mj`.
  - A tap with `k-i < 0` contributes 0.
  - At `i == N-1`, the final sum is written to `result[k]`, the accumulator is cleared, and `k` increments.
  - `operation` is ignored until finished. Completion of the last MAC -> DONE.
- DONE:
  - `done` = 1.
  - op 11: `y_rns <= result[addr]` each cycle, or 0 if `addr >= SIGNAL_COUNT`.
  - op 01 -> LOAD, `done <= 0`, and the sample is written.
  - op 00 and op 10 are ignored.
- Coefficients are per-channel residues of the integer taps `h[i] = i+1` and are precomputed constants.
- Arithmetic widths: residues are 8 bits; products are 16 bits before reduction. An accumulator never holds a value `>= Mj`.
- Residue inputs are not range-checked. Residues are only defined for values `< Mj`, and the encoder guarantees this.

## Timing
- Reset asserted: state IDLE, `done` = 0, `y_rns` = 0, and all sample, result and accumulator registers = 0. This takes effect immediately, including mid-COMPUTE.
- Sample write: takes effect on the edge where op 01 is sampled. There is no backpressure.
- Compute latency: op 10 sampled at edge T.
  - MACs run on edges T+1 .. T+`SIGNAL_COUNT`*`N`.
  - `done` rises at edge T+`SIGNAL_COUNT`*`N`+1, which is 101 for the defaults.
- Read latency: one cycle. `addr` sampled at edge t gives `y_rns` valid after edge t.
- `y_rns` holds its last value outside op 11 reads.
- `done` stays high until reset or the next op 01.

## Structure
- Package `rns_fir_pkg` holds:
  - the moduli constants;
  - the operation enum (`OP_IDLE`, `OP_LOAD`, `OP_COMPUTE`, `OP_READ`);
  - the state enum;
  - the coefficient residue table as a function of `N`;
  - the `residue_t` (8-bit) typedef.
- Sub-module `rns_mac_channel` (parameter `M`) provides one modulus channel: reduced multiply-accumulate plus clear. It is instantiated four times.
- Top-level logic: FSM, `k`/`i` counters, sample and result arrays, and the read mux.

## Test plan
- Load samples 0..9 (residues = value), compute, read addr 0/1/2/9 -> `y_rns` = 0x00000000 / 0x01010101 / 0x04040404 / 0xA5A5A5A5 (y = 0, 1, 4, 165).
- Load all samples = 200, compute, read addr 9 -> `y_rns` = 0xCF9B0631, i.e. 11000 mod (233, 239, 241, 251) = 49, 6, 155, 207. This checks modular wrap per channel.
- Extra write at addr 10 with `x_rns` = 0xFFFFFFFF during LOAD -> results identical to the first scenario. Read addr 10 or 0xFFFFFFFF -> `y_rns` = 0.
- Issue op 10 and count cycles -> `done` rises exactly 101 edges later. Toggling `operation` to 01 mid-compute has no effect on timing or results.
- Assert reset at cycle 50 of COMPUTE -> `done` = 0 and `y_rns` = 0 immediately, without waiting for an edge. Full reload and compute gives the correct results.
- After DONE, issue op 01 -> `done` falls on that edge. Reload samples 9..0 and recompute -> addr 0 reads 0x09090909.
